// File: rtl/wb_writeback.sv
// wb_writeback: MEM/WB writeback stage with 16x32 scalar and 8x32 vector
// register files, a byte-lane packing FSM, and combinational read ports.
// Ports: clk, rst_n (sync, active-low); Do/Dob/ALU_Result write data;
// Rg destination; WE_C/WE_V enables; SEL_DAT/SEL_C scalar select;
// SEL_STO vector pack mode; FLUSH; RA_A/RA_B -> RD_A/RD_B; RV_A -> VD_A;
// PACK_BUSY; WB_STALL (hold request to MEM/WB).
// Optional macro WB_BYPASS_EN: same-cycle write-to-read bypass.
module wb_writeback #(
  parameter int NSREG = 16,
  parameter int NVREG = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Do,
  input  logic [7:0]  Dob,
  input  logic [31:0] ALU_Result,
  input  logic [3:0]  Rg,
  input  logic        WE_C,
  input  logic        WE_V,
  input  logic        SEL_DAT,
  input  logic        SEL_C,
  input  logic        SEL_STO,
  input  logic        FLUSH,
  input  logic [3:0]  RA_A,
  input  logic [3:0]  RA_B,
  output logic [31:0] RD_A,
  output logic [31:0] RD_B,
  input  logic [2:0]  RV_A,
  output logic [31:0] VD_A,
  output logic        PACK_BUSY,
  output logic        WB_STALL
);

  typedef enum logic {
    S_IDLE,
    S_PACK
  } state_t;

  logic [31:0] r_sreg [NSREG];
  logic [31:0] r_vreg [NVREG];

  state_t      r_state, w_state_nx;
  logic [1:0]  r_lane, w_lane_nx;
  logic [31:0] r_acc, w_acc_nx;
  logic [3:0]  r_fm, w_fm_nx;
  logic [2:0]  r_vtgt, w_vtgt_nx;

  logic        w_commit;
  logic [2:0]  w_cm_tgt;
  logic [31:0] w_cm_acc;
  logic [3:0]  w_cm_fm;
  logic [31:0] w_cm_old;
  logic [31:0] w_cm_data;

  logic [31:0] w_acc_ins;
  logic [3:0]  w_fm_ins;
  logic [31:0] w_sdata;
  logic        w_pack;
  logic        w_direct;
  logic        w_busy;
  logic        w_stall;
  logic        w_dwr;
  logic        w_same;

  assign w_busy   = (r_state == S_PACK);
  assign w_pack   = WE_V & SEL_STO;
  assign w_direct = WE_V & ~SEL_STO;
  assign w_stall  = w_direct & w_busy;
  assign w_dwr    = w_direct & ~w_busy;
  assign w_same   = (r_vtgt == Rg[2:0]);

  assign PACK_BUSY = w_busy;
  assign WB_STALL  = w_stall;

  // SEL_C byte mode takes priority over the Do/ALU select
  assign w_sdata = SEL_C   ? {24'b0, Dob} :
                   SEL_DAT ? Do : ALU_Result;

  // Accumulator/mask as they would be after taking Dob into the open lane
  always_comb begin
    w_acc_ins = r_acc;
    w_acc_ins[{r_lane, 3'b000} +: 8] = Dob;
    w_fm_ins = r_fm | (4'b0001 << r_lane);
  end

  always_comb begin
    w_state_nx = r_state;
    w_lane_nx  = r_lane;
    w_acc_nx   = r_acc;
    w_fm_nx    = r_fm;
    w_vtgt_nx  = r_vtgt;
    w_commit   = 1'b0;
    w_cm_tgt   = r_vtgt;
    w_cm_acc   = r_acc;
    w_cm_fm    = r_fm;
    unique case (r_state)
      S_IDLE: begin
        if (w_pack) begin
          w_state_nx = S_PACK;
          w_acc_nx   = {24'b0, Dob};
          w_fm_nx    = 4'b0001;
          w_lane_nx  = 2'd1;
          w_vtgt_nx  = Rg[2:0];
        end
      end
      S_PACK: begin
        if (w_stall) begin
          // drain the partial; the held direct write retries next cycle
          w_commit   = 1'b1;
          w_state_nx = S_IDLE;
          w_lane_nx  = 2'd0;
          w_acc_nx   = '0;
          w_fm_nx    = '0;
        end else if (w_pack && w_same) begin
          w_cm_acc = w_acc_ins;
          w_cm_fm  = w_fm_ins;
          if (r_lane == 2'd3 || FLUSH) begin
            w_commit   = 1'b1;
            w_state_nx = S_IDLE;
            w_lane_nx  = 2'd0;
            w_acc_nx   = '0;
            w_fm_nx    = '0;
          end else begin
            w_acc_nx  = w_acc_ins;
            w_fm_nx   = w_fm_ins;
            w_lane_nx = r_lane + 2'd1;
          end
        end else if (w_pack) begin
          // retarget: close the old partial and open the new one at once
          w_commit  = 1'b1;
          w_acc_nx  = {24'b0, Dob};
          w_fm_nx   = 4'b0001;
          w_lane_nx = 2'd1;
          w_vtgt_nx = Rg[2:0];
        end else if (FLUSH) begin
          w_commit   = 1'b1;
          w_state_nx = S_IDLE;
          w_lane_nx  = 2'd0;
          w_acc_nx   = '0;
          w_fm_nx    = '0;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Unfilled lanes keep the register's previous bytes
  assign w_cm_old = r_vreg[w_cm_tgt];
  always_comb begin
    w_cm_data = w_cm_old;
    for (int i = 0; i < 4; i++) begin
      if (w_cm_fm[i]) w_cm_data[i*8 +: 8] = w_cm_acc[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_lane  <= '0;
      r_acc   <= '0;
      r_fm    <= '0;
      r_vtgt  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_lane  <= w_lane_nx;
      r_acc   <= w_acc_nx;
      r_fm    <= w_fm_nx;
      r_vtgt  <= w_vtgt_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NSREG; i++) r_sreg[i] <= '0;
    end else if (WE_C) begin
      r_sreg[Rg] <= w_sdata;
    end
  end

  // Commit and direct write are exclusive: commits need PACK, direct needs IDLE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NVREG; i++) r_vreg[i] <= '0;
    end else if (w_commit) begin
      r_vreg[w_cm_tgt] <= w_cm_data;
    end else if (w_dwr) begin
      r_vreg[Rg[2:0]] <= Do;
    end
  end

`ifdef WB_BYPASS_EN
  assign RD_A = (WE_C && RA_A == Rg) ? w_sdata : r_sreg[RA_A];
  assign RD_B = (WE_C && RA_B == Rg) ? w_sdata : r_sreg[RA_B];
  assign VD_A = (w_dwr && RV_A == Rg[2:0]) ? Do : r_vreg[RV_A];
`else
  assign RD_A = r_sreg[RA_A];
  assign RD_B = r_sreg[RA_B];
  assign VD_A = r_vreg[RV_A];
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// tb_wb_writeback: scoreboard-driven bench for wb_writeback.
// Expected values are queued at drive time and popped at each check.
module tb_wb_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] Do;
  logic [7:0]  Dob;
  logic [31:0] ALU_Result;
  logic [3:0]  Rg;
  logic        WE_C, WE_V, SEL_DAT, SEL_C, SEL_STO, FLUSH;
  logic [3:0]  RA_A, RA_B;
  logic [31:0] RD_A, RD_B;
  logic [2:0]  RV_A;
  logic [31:0] VD_A;
  logic        PACK_BUSY, WB_STALL;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];
  logic [31:0] exp;

  wb_writeback dut (
    .clk(clk), .rst_n(rst_n), .Do(Do), .Dob(Dob),
    .ALU_Result(ALU_Result), .Rg(Rg), .WE_C(WE_C), .WE_V(WE_V),
    .SEL_DAT(SEL_DAT), .SEL_C(SEL_C), .SEL_STO(SEL_STO), .FLUSH(FLUSH),
    .RA_A(RA_A), .RA_B(RA_B), .RD_A(RD_A), .RD_B(RD_B),
    .RV_A(RV_A), .VD_A(VD_A), .PACK_BUSY(PACK_BUSY), .WB_STALL(WB_STALL)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    WE_C = 0; WE_V = 0; SEL_DAT = 0; SEL_C = 0;
    SEL_STO = 0; FLUSH = 0;
  endtask

  task automatic vdirect(input logic [2:0] r, input logic [31:0] d);
    idle();
    WE_V = 1; Rg = {1'b0, r}; Do = d;
    tick();
    idle();
  endtask

  task automatic pack(input logic [3:0] r, input logic [7:0] b);
    idle();
    WE_V = 1; SEL_STO = 1; Rg = r; Dob = b;
  endtask

  task automatic test_reset();
    rst_n = 0; idle();
    Do = 0; Dob = 0; ALU_Result = 0; Rg = 0;
    RA_A = 0; RA_B = 0; RV_A = 0;
    tick(); tick();
    rst_n = 1;
    WE_C = 1; Rg = 5; ALU_Result = 32'hDEADBEEF;
    sb.push_back(32'hDEADBEEF);
    tick(); idle();
    RA_A = 5; #1;
    exp = sb.pop_front(); tests++;
    if (RD_A !== exp) begin
      $display("FAIL reset_pre_write RD_A=%h exp=%h", RD_A, exp); fails++;
    end
    pack(4'd0, 8'h5A);
    tick();
    tests++;
    if (PACK_BUSY !== 1'b1) begin
      $display("FAIL reset_pack_open busy=%b exp=1", PACK_BUSY); fails++;
    end
    rst_n = 0;
    sb.push_back(32'h0);
    sb.push_back(32'h0);
    tick();
    rst_n = 1; idle(); RV_A = 0; #1;
    exp = sb.pop_front(); tests++;
    if (RD_A !== exp) begin
      $display("FAIL reset_sreg RD_A=%h exp=%h", RD_A, exp); fails++;
    end
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL reset_discard VD_A=%h exp=%h", VD_A, exp); fails++;
    end
    tests++;
    if (PACK_BUSY !== 1'b0 || WB_STALL !== 1'b0) begin
      $display("FAIL reset_flags busy=%b stall=%b exp=0 0",
               PACK_BUSY, WB_STALL); fails++;
    end
  endtask

  task automatic test_scalar_sel();
    logic [2:0] mode;
    RA_A = 3;
    for (int i = 0; i < 4; i++) begin
      idle();
      WE_C = 1; Rg = 3;
      ALU_Result = 32'h12345678; Do = 32'hCAFEF00D; Dob = 8'hA5;
      mode = 3'(i);
      SEL_DAT = (mode == 1 || mode == 3);
      SEL_C = (mode >= 2);
      if (mode == 0)      sb.push_back(32'h12345678);
      else if (mode == 1) sb.push_back(32'hCAFEF00D);
      else                sb.push_back(32'h000000A5);
      tick(); idle(); #1;
      exp = sb.pop_front(); tests++;
      if (RD_A !== exp) begin
        $display("FAIL scalar_sel_%0d RD_A=%h exp=%h", i, RD_A, exp);
        fails++;
      end
    end
  endtask

  task automatic test_full_pack();
    logic [7:0] bytes [4];
    bytes[0] = 8'h11; bytes[1] = 8'h22;
    bytes[2] = 8'h33; bytes[3] = 8'h44;
    vdirect(3'd2, 32'hFFFFFFFF);
    RV_A = 2;
    for (int i = 0; i < 4; i++) begin
      pack(4'd2, bytes[i]);
      sb.push_back(i < 3 ? 32'h1 : 32'h0);
      sb.push_back(i < 3 ? 32'hFFFFFFFF : 32'h44332211);
      tick();
      exp = sb.pop_front(); tests++;
      if ({31'b0, PACK_BUSY} !== exp) begin
        $display("FAIL full_pack_busy_%0d busy=%b exp=%0d",
                 i, PACK_BUSY, exp); fails++;
      end
      idle(); #1;
      exp = sb.pop_front(); tests++;
      if (VD_A !== exp) begin
        $display("FAIL full_pack_vd_%0d VD_A=%h exp=%h", i, VD_A, exp);
        fails++;
      end
    end
  endtask

  task automatic test_retarget();
    vdirect(3'd1, 32'hAABBCCDD);
    vdirect(3'd4, 32'h11223344);
    pack(4'd1, 8'h01); tick();
    pack(4'd1, 8'h02); tick();
    pack(4'd4, 8'h09);
    sb.push_back(32'hAABB0201);
    tick();
    idle(); RV_A = 1; #1;
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL retarget_old VD_A=%h exp=%h", VD_A, exp); fails++;
    end
    tests++;
    if (PACK_BUSY !== 1'b1) begin
      $display("FAIL retarget_busy busy=%b exp=1", PACK_BUSY); fails++;
    end
    FLUSH = 1;
    sb.push_back(32'h11223309);
    tick();
    idle(); RV_A = 4; #1;
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL retarget_flush VD_A=%h exp=%h", VD_A, exp); fails++;
    end
    tests++;
    if (PACK_BUSY !== 1'b0) begin
      $display("FAIL retarget_idle busy=%b exp=0", PACK_BUSY); fails++;
    end
  endtask

  task automatic test_back_to_back();
    RV_A = 3;
    pack(4'd3, 8'hA1); tick();
    idle(); tick();
    tests++;
    if (PACK_BUSY !== 1'b1) begin
      $display("FAIL gap_busy busy=%b exp=1", PACK_BUSY); fails++;
    end
    pack(4'd3, 8'hB2); tick();
    pack(4'd3, 8'hC3); FLUSH = 1;
    sb.push_back(32'h00C3B2A1);
    tick();
    idle(); #1;
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL flush_with_byte VD_A=%h exp=%h", VD_A, exp); fails++;
    end
  endtask

  task automatic test_conflict();
    RV_A = 6;
    pack(4'd6, 8'h77); tick();
    idle();
    WE_V = 1; SEL_STO = 0; Rg = 6; Do = 32'h0BADCAFE;
    #1;
    tests++;
    if (WB_STALL !== 1'b1) begin
      $display("FAIL conflict_stall stall=%b exp=1", WB_STALL); fails++;
    end
`ifdef WB_BYPASS_EN
    sb.push_back(32'h0BADCAFE);
`else
    sb.push_back(32'h00000077);
`endif
    tick();
    tests++;
    if (WB_STALL !== 1'b0 || PACK_BUSY !== 1'b0) begin
      $display("FAIL conflict_release stall=%b busy=%b exp=0 0",
               WB_STALL, PACK_BUSY); fails++;
    end
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL conflict_drain VD_A=%h exp=%h", VD_A, exp); fails++;
    end
    sb.push_back(32'h0BADCAFE);
    tick();
    idle(); #1;
    exp = sb.pop_front(); tests++;
    if (VD_A !== exp) begin
      $display("FAIL conflict_retry VD_A=%h exp=%h", VD_A, exp); fails++;
    end
  endtask

  task automatic test_bypass();
    idle();
    WE_C = 1; Rg = 7; RA_B = 7; ALU_Result = 32'h55AA55AA;
`ifdef WB_BYPASS_EN
    sb.push_back(32'h55AA55AA);
`else
    sb.push_back(32'h0);
`endif
    sb.push_back(32'h55AA55AA);
    #1;
    exp = sb.pop_front(); tests++;
    if (RD_B !== exp) begin
      $display("FAIL bypass_same RD_B=%h exp=%h", RD_B, exp); fails++;
    end
    tick(); idle(); #1;
    exp = sb.pop_front(); tests++;
    if (RD_B !== exp) begin
      $display("FAIL bypass_after RD_B=%h exp=%h", RD_B, exp); fails++;
    end
  endtask

  initial begin
    test_reset();
    test_scalar_sel();
    test_full_pack();
    test_retarget();
    test_back_to_back();
    test_conflict();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
